// File: rtl/loop_nest_counter_if.sv
// Control, limit and status bundle for loop_nest_counter.
// master drives start/clear/advance and limits; slave returns position and completion.
interface loop_nest_counter_if #(
  parameter int COL_WIDTH = 5,
  parameter int ROW_WIDTH = 5,
  parameter int CH_WIDTH  = 4,
  parameter int IDX_WIDTH = 14
);
  logic                 i_clr;
  logic                 i_start;
  logic                 i_ce;
  logic [COL_WIDTH-1:0] i_col_last;
  logic [ROW_WIDTH-1:0] i_row_last;
  logic [CH_WIDTH-1:0]  i_ch_last;
  logic [COL_WIDTH-1:0] o_col;
  logic [ROW_WIDTH-1:0] o_row;
  logic [CH_WIDTH-1:0]  o_ch;
  logic [IDX_WIDTH-1:0] o_index;
  logic                 o_busy;
  logic                 o_col_wrap;
  logic                 o_row_wrap;
  logic                 o_last;
  logic                 o_done_pulse;
  logic                 o_done;

  modport master (
    output i_clr, i_start, i_ce, i_col_last, i_row_last, i_ch_last,
    input  o_col, o_row, o_ch, o_index, o_busy, o_col_wrap, o_row_wrap,
           o_last, o_done_pulse, o_done
  );

  modport slave (
    input  i_clr, i_start, i_ce, i_col_last, i_row_last, i_ch_last,
    output o_col, o_row, o_ch, o_index, o_busy, o_col_wrap, o_row_wrap,
           o_last, o_done_pulse, o_done
  );
endinterface

// File: rtl/loop_nest_counter.sv
// Three-level col/row/ch sweep counter with latched limits and start/done handshake.
// Counters move on the edge i_ce is sampled; wrap/last flags are same-cycle comb; i_ce low stalls.
module loop_nest_counter #(
  parameter int COL_WIDTH = 5,
  parameter int ROW_WIDTH = 5,
  parameter int CH_WIDTH  = 4,
  parameter int IDX_WIDTH = 14
) (
  input logic               clk,
  input logic               global_rst_n,
  loop_nest_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_nxt;
  logic [COL_WIDTH-1:0] col_q, col_nxt, col_last_q;
  logic [ROW_WIDTH-1:0] row_q, row_nxt, row_last_q;
  logic [CH_WIDTH-1:0]  ch_q, ch_nxt, ch_last_q;
  logic [IDX_WIDTH-1:0] idx_q, idx_nxt;
  logic                 done_q, done_nxt;
  logic                 pulse_q, pulse_nxt;
  logic                 load_lim;
  logic                 busy, col_wrap, row_wrap, last;

  assign busy     = (state_q == RUN);
  assign col_wrap = busy && (col_q == col_last_q);
  assign row_wrap = col_wrap && (row_q == row_last_q);
  assign last     = row_wrap && (ch_q == ch_last_q);

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      col_q   <= col_nxt;
      row_q   <= row_nxt;
      ch_q    <= ch_nxt;
      idx_q   <= idx_nxt;
      done_q  <= done_nxt;
      pulse_q <= pulse_nxt;
    end
  end

  // Limits survive i_clr; only a new start replaces them.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col_last_q <= '0;
      row_last_q <= '0;
      ch_last_q  <= '0;
    end else if (load_lim) begin
      col_last_q <= bus.i_col_last;
      row_last_q <= bus.i_row_last;
      ch_last_q  <= bus.i_ch_last;
    end
  end

  always_comb begin
    state_nxt = state_q;
    col_nxt   = col_q;
    row_nxt   = row_q;
    ch_nxt    = ch_q;
    idx_nxt   = idx_q;
    done_nxt  = done_q;
    pulse_nxt = 1'b0;
    load_lim  = 1'b0;
    if (bus.i_clr) begin
      state_nxt = IDLE;
      col_nxt   = '0;
      row_nxt   = '0;
      ch_nxt    = '0;
      idx_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (bus.i_start) begin
      // A start seen during RUN also swallows that cycle's i_ce.
      if (state_q != RUN) begin
        load_lim  = 1'b1;
        state_nxt = RUN;
        col_nxt   = '0;
        row_nxt   = '0;
        ch_nxt    = '0;
        idx_nxt   = '0;
        done_nxt  = 1'b0;
      end
    end else if (busy && bus.i_ce) begin
      if (last) begin
        state_nxt = DONE;
        col_nxt   = '0;
        row_nxt   = '0;
        ch_nxt    = '0;
        idx_nxt   = '0;
        done_nxt  = 1'b1;
        pulse_nxt = 1'b1;
      end else begin
        idx_nxt = idx_q + IDX_WIDTH'(1);
        if (!col_wrap) begin
          col_nxt = col_q + COL_WIDTH'(1);
        end else begin
          col_nxt = '0;
          if (!row_wrap) begin
            row_nxt = row_q + ROW_WIDTH'(1);
          end else begin
            row_nxt = '0;
            ch_nxt  = ch_q + CH_WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.o_col        = col_q;
  assign bus.o_row        = row_q;
  assign bus.o_ch         = ch_q;
  assign bus.o_index      = idx_q;
  assign bus.o_busy       = busy;
  assign bus.o_col_wrap   = col_wrap;
  assign bus.o_row_wrap   = row_wrap;
  assign bus.o_last       = last;
  assign bus.o_done_pulse = pulse_q;
  assign bus.o_done       = done_q;

endmodule

// File: tb/tb_loop_nest_counter.sv
// Bench for loop_nest_counter: constant vector table, directed corner sequences,
// and random traffic against a step-count reference model.
module tb_loop_nest_counter;

  logic clk = 1'b0;
  logic global_rst_n = 1'b0;
  always #5 clk = ~clk;

  loop_nest_counter_if #(.COL_WIDTH(5), .ROW_WIDTH(5), .CH_WIDTH(4), .IDX_WIDTH(14)) bus ();

  loop_nest_counter #(.COL_WIDTH(5), .ROW_WIDTH(5), .CH_WIDTH(4), .IDX_WIDTH(14)) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .bus          (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a sweep is just a step number k in [0, total).
  int m_state = 0;   // 0 idle, 1 run, 2 done
  int m_k = 0, m_cl = 0, m_rl = 0, m_chl = 0;
  bit m_done = 0, m_pulse = 0;

  typedef struct {
    logic        clr, start, ce;
    logic [4:0]  cl, rl;
    logic [3:0]  chl;
    logic [4:0]  col;
    logic [13:0] idx;
    logic        busy, last, pulse, done;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [33:0] dut_vec();
    return {bus.o_col, bus.o_row, bus.o_ch, bus.o_index, bus.o_busy, bus.o_col_wrap,
            bus.o_row_wrap, bus.o_last, bus.o_done_pulse, bus.o_done};
  endfunction

  function automatic logic [33:0] model_vec();
    int w0 = m_cl + 1;
    int w1 = m_rl + 1;
    int tot = w0 * w1 * (m_chl + 1);
    int col = m_k % w0;
    int row = (m_k / w0) % w1;
    int ch  = m_k / (w0 * w1);
    bit run = (m_state == 1);
    bit cw  = run && (col == m_cl);
    bit rw  = cw && (row == m_rl);
    bit lst = run && (m_k == tot - 1);
    return {5'(col), 5'(row), 4'(ch), 14'(m_k), run, cw, rw, lst, m_pulse, m_done};
  endfunction

  function automatic void model_edge(input bit clr, start, ce, input int cl, rl, chl);
    int tot = (m_cl + 1) * (m_rl + 1) * (m_chl + 1);
    m_pulse = 0;
    if (clr) begin
      m_state = 0; m_k = 0; m_done = 0;
    end else if (start) begin
      if (m_state != 1) begin
        m_state = 1; m_k = 0; m_done = 0; m_cl = cl; m_rl = rl; m_chl = chl;
      end
    end else if (m_state == 1 && ce) begin
      if (m_k == tot - 1) begin
        m_state = 2; m_k = 0; m_done = 1; m_pulse = 1;
      end else begin
        m_k++;
      end
    end
  endfunction

  function automatic void model_reset();
    m_state = 0; m_k = 0; m_cl = 0; m_rl = 0; m_chl = 0; m_done = 0; m_pulse = 0;
  endfunction

  task automatic cyc(input bit clr, start, ce, input int cl, rl, chl);
    bus.i_clr      = clr;
    bus.i_start    = start;
    bus.i_ce       = ce;
    bus.i_col_last = 5'(cl);
    bus.i_row_last = 5'(rl);
    bus.i_ch_last  = 4'(chl);
    @(posedge clk);
    model_edge(clr, start, ce, cl, rl, chl);
    #1;
  endtask

  task automatic chk_model(input string name);
    chk(name, 64'(dut_vec()), 64'(model_vec()));
  endtask

  vec_t tbl[9];
  int   steps;
  bit   last_seen;
  logic [13:0] idx_at_last;

  initial begin
    bus.i_clr = 0; bus.i_start = 0; bus.i_ce = 0;
    bus.i_col_last = '0; bus.i_row_last = '0; bus.i_ch_last = '0;
    model_reset();

    // Reset state
    #2;
    chk("reset_outputs", 64'(dut_vec()), 64'd0);
    @(negedge clk);
    global_rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk_model("idle_after_reset");

    // Degenerate sweep, restart from DONE with start-in-RUN ignored, then clear.
    //            clr st ce cl rl ch  col idx busy last pulse done
    tbl[0] = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0};
    tbl[5] = '{0, 1, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0};
    tbl[6] = '{0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 1};
    tbl[7] = '{0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[8] = '{1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].clr, tbl[i].start, tbl[i].ce, int'(tbl[i].cl), int'(tbl[i].rl), int'(tbl[i].chl));
      chk($sformatf("tbl_%0d", i),
          64'({bus.o_col, bus.o_index, bus.o_busy, bus.o_last, bus.o_done_pulse, bus.o_done}),
          64'({tbl[i].col, tbl[i].idx, tbl[i].busy, tbl[i].last, tbl[i].pulse, tbl[i].done}));
    end

    // Basic sweep 2,1,1 with ce held high: 12 steps
    cyc(0, 1, 0, 2, 1, 1);
    chk_model("basic_start");
    steps = 0;
    last_seen = 0;
    for (int i = 0; i < 40 && !last_seen; i++) begin
      steps++;
      last_seen = bus.o_last;
      cyc(0, 0, 1, 2, 1, 1);
      chk_model("basic_step");
    end
    chk("basic_step_count", 64'(steps), 64'd12);
    chk("basic_pulse", 64'(bus.o_done_pulse), 64'd1);
    cyc(0, 0, 0, 2, 1, 1);
    chk("basic_pulse_drop_done_hold", 64'({bus.o_done_pulse, bus.o_done}), 64'b01);

    // Gapped ce: same sweep, ce toggling
    cyc(0, 1, 0, 2, 1, 1);
    last_seen = 0;
    idx_at_last = '1;
    for (int i = 0; i < 60 && !last_seen; i++) begin
      if (i % 2 == 0) begin
        last_seen = bus.o_last;
        if (last_seen) idx_at_last = bus.o_index;
      end
      cyc(0, 0, (i % 2 == 0), 2, 1, 1);
      chk_model("gapped_step");
    end
    chk("gapped_final_index", 64'(idx_at_last), 64'd11);

    // Mid-sweep clear with start and ce also asserted
    cyc(0, 1, 0, 3, 3, 3);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 3, 3, 3);
    chk_model("mid_sweep_20");
    chk("mid_sweep_index", 64'(bus.o_index), 64'd20);
    cyc(1, 1, 1, 3, 3, 3);
    chk("clear_outputs", 64'(dut_vec()), 64'd0);
    cyc(0, 1, 0, 3, 3, 3);
    chk("restart_after_clear", 64'({bus.o_busy, bus.o_index, bus.o_col}), 64'({1'b1, 14'd0, 5'd0}));

    // Async reset between edges mid-RUN
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3, 3, 3);
    #3;
    global_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(dut_vec()), 64'd0);
    model_reset();
    @(negedge clk);
    global_rst_n = 1'b1;
    cyc(0, 0, 1, 3, 3, 3);
    chk_model("idle_after_async_reset");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 10) == 0, ($urandom % 10) < 7,
          int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      chk_model("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
